// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory pipeline stage: pass-through for ALU ops, blocking lw/sw handshake with timeout
module mem_stage #(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [31:0]       xm_o,
  input  logic [31:0]       xm_b,
  input  logic [31:0]       xm_ir,
  input  logic              xm_ovf,
  input  logic              xm_valid,
  output logic              stall,
  output logic [31:0]       mw_o,
  output logic [31:0]       mw_d,
  output logic [31:0]       mw_ir,
  output logic              mw_ovf,
  output logic              mw_en,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              mem_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [4:0] OP_LW    = 5'b01000;
  localparam logic [4:0] OP_SW    = 5'b00111;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] o_q, o_d;
  logic [31:0] b_q, b_d;
  logic [31:0] ir_q, ir_d;
  logic        ovf_q, ovf_d;
  logic [31:0] ld_q, ld_d;
  logic        err_q, err_d;
  logic        stall_c;
  logic        is_mem;
  logic        cap_sw;

  assign is_mem = xm_valid && ((xm_ir[31:27] == OP_LW) || (xm_ir[31:27] == OP_SW));
  assign cap_sw = (ir_q[31:27] == OP_SW);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      o_q     <= '0;
      b_q     <= '0;
      ir_q    <= '0;
      ovf_q   <= 1'b0;
      ld_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      o_q     <= o_d;
      b_q     <= b_d;
      ir_q    <= ir_d;
      ovf_q   <= ovf_d;
      ld_q    <= ld_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    o_d     = o_q;
    b_d     = b_q;
    ir_d    = ir_q;
    ovf_d   = ovf_q;
    ld_d    = ld_q;
    err_d   = err_q;
    stall_c = 1'b0;
    mw_en   = 1'b0;
    mw_o    = '0;
    mw_d    = '0;
    mw_ir   = '0;
    mw_ovf  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (is_mem) begin
          stall_c = 1'b1;
          o_d     = xm_o;
          b_d     = xm_b;
          ir_d    = xm_ir;
          ovf_d   = xm_ovf;
          ld_d    = '0;
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          mw_en = 1'b1;
          if (xm_valid) begin
            mw_o   = xm_o;
            mw_ir  = xm_ir;
            mw_ovf = xm_ovf;
          end
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + 8'd1;
        // an ack in the final counted cycle still completes normally
        if (mem_ack) begin
          ld_d    = cap_sw ? 32'd0 : mem_rdata;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          ld_d    = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        mw_en   = 1'b1;
        mw_o    = o_q;
        mw_d    = ld_q;
        mw_ir   = ir_q;
        mw_ovf  = ovf_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // stall is gated by clr so upstream is released as soon as reset asserts
  assign stall     = clr && stall_c;
  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = mem_req && cap_sw;
  assign mem_addr  = o_q[ADDR_W-1:0];
  assign mem_wdata = b_q;
  assign mem_err   = err_q;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_W, default 12, data-memory word-address width.
REQ-002 Parameter TIMEOUT, default 16, max cycles in REQ awaiting mem_ack; legal range 2..255.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 clr  input  1  reset: asynchronous, active-low; clr=0 forces reset state immediately.
REQ-005 xm_o  input  32  ALU result from X/M latch; memory address for lw/sw.
REQ-006 xm_b  input  32  store data from X/M latch.
REQ-007 xm_ir  input  32  instruction from X/M latch; opcode = xm_ir[31:27].
REQ-008 xm_ovf  input  1  overflow flag from X/M latch.
REQ-009 xm_valid  input  1  X/M latch holds a real instruction.
REQ-010 stall  output  1  upstream SHALL hold the X/M latch while 1.
REQ-011 mw_o, mw_d, mw_ir  output  32 each  data presented to the M/W latch.
REQ-012 mw_ovf  output  1  overflow presented to the M/W latch.
REQ-013 mw_en  output  1  enable for the M/W latch.
REQ-014 mem_req  output  1  memory request, held until ack or timeout.
REQ-015 mem_we  output  1  1 = store, 0 = load; valid while mem_req=1.
REQ-016 mem_addr  output  ADDR_W  = captured xm_o[ADDR_W-1:0].
REQ-017 mem_wdata  output  32  captured xm_b.
REQ-018 mem_ack  input  1  memory completed the request this cycle.
REQ-019 mem_rdata  input  32  load data, valid in the mem_ack cycle.
REQ-020 mem_err  output  1  sticky timeout flag.

Function
REQ-021 Memory op: opcode 01000 (lw) or 00111 (sw) with xm_valid=1; all other instructions are non-memory.
REQ-022 FSM states IDLE, REQ, DONE; encoding is free.
REQ-023 IDLE, xm_valid=0: stall=0, mw_en=1, all mw_* = 0 (nop bubble).
REQ-024 IDLE, valid non-memory op: stall=0, mw_en=1, mw_o=xm_o, mw_ir=xm_ir, mw_ovf=xm_ovf, mw_d=0; same-cycle pass-through, zero latency.
REQ-025 IDLE, memory op: stall=1, mw_en=0; capture xm_o, xm_b, xm_ir, xm_ovf and clear the wait counter at the edge; next state REQ.
REQ-026 REQ: mem_req=1, mem_we=1 iff captured opcode is sw, stall=1, mw_en=0; counter increments each cycle.
REQ-027 REQ with mem_ack=1: capture mem_rdata for lw, 0 for sw; next state DONE.
REQ-028 REQ, no ack, counter = TIMEOUT-1: load data = 0, mem_err set to 1; next state DONE.
REQ-029 Ack and timeout in the same cycle: ack wins and mem_err is not set.
REQ-030 mem_req SHALL drop in the cycle after ack or timeout; mem_ack outside REQ is ignored.
REQ-031 DONE: stall=0, mw_en=1, mw_o/mw_ir/mw_ovf = captured values, mw_d = captured load data; next state IDLE unconditionally.
REQ-032 DONE never accepts xm_*; the upstream advances at the DONE edge and IDLE sees the next instruction.
REQ-033 Memory-op latency from IDLE capture to mw_en: k+2 cycles, where k = cycles in REQ including the ack cycle.
REQ-034 xm_ovf=1 on lw/sw does not suppress the access; ovf is forwarded unchanged.
REQ-035 mem_addr, mem_wdata and mem_we SHALL be stable from the REQ entry cycle through the ack cycle.

Reset
REQ-036 While clr=0: state=IDLE, counter=0, captured registers=0, mem_err=0, mem_req=0, mem_we=0, stall=0.
REQ-037 Reset during REQ SHALL abort the access: mem_req drops asynchronously and no M/W write occurs for that instruction.
REQ-038 mem_err is cleared only by reset.

Verification
REQ-039 Reset, then add with xm_ir[31:27]=00000 and xm_o=5 -> same cycle: mw_en=1, mw_o=5, stall=0.
REQ-040 sw with xm_o=0x10, xm_b=0xDEAD, ack on the 3rd REQ cycle -> mem_req for 3 cycles, mem_addr=0x010, mem_we=1, wdata=0xDEAD; DONE mw_d=0; stall=1 for 4 cycles.
REQ-041 lw with xm_o=0x1FFF, ack in the first REQ cycle with rdata=0x12345678 -> mem_addr=0xFFF, mw_d=0x12345678 in DONE, total latency 3.
REQ-042 lw with no ack -> mem_req high exactly 16 cycles, then DONE with mw_d=0, mem_err=1 sticky across later instructions.
REQ-043 Back-to-back lw, lw, add -> each lw runs IDLE/REQ/DONE in turn; add passes through in IDLE right after the second DONE; the M/W latch sees no duplicate.
REQ-044 clr=0 in the 2nd REQ cycle -> mem_req=0 and stall=0 immediately; after release, state IDLE and mem_err=0.
